// File: rtl/serial_deserializer_pkg.sv
// deser_pkg: shared constants for serial_deserializer.
// Defining DESER_PARITY_EN appends one even-parity bit to every serial frame.
package deser_pkg;
  localparam int DEF_WIDTH = 4;
`ifdef DESER_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  localparam int CNT_W = $clog2(DEF_WIDTH + 1);
  typedef logic [CNT_W-1:0] cnt_t;
  function automatic int frame_len(input int w);
    return w + PAR_BITS;
  endfunction
endpackage

// File: rtl/serial_deserializer_if.sv
// serial_deserializer_if: serial bit input and parallel word output handshakes.
interface serial_deserializer_if
  import deser_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic clear;
  logic in_bit;
  logic in_valid;
  logic in_ready;
  logic [WIDTH-1:0] out_data;
  logic out_err;
  logic out_valid;
  logic out_ready;
  modport master (
    output clear, in_bit, in_valid, out_ready,
    input  in_ready, out_data, out_err, out_valid
  );
  modport slave (
    input  clear, in_bit, in_valid, out_ready,
    output in_ready, out_data, out_err, out_valid
  );
endinterface

// File: rtl/serial_deserializer_demux.sv
// demux1toN: steers a single write strobe onto one of WIDTH one-hot enables.
module demux1toN #(
  parameter int WIDTH = 4,
  parameter int SEL_W = 3
) (
  input  logic             din,
  input  logic [SEL_W-1:0] sel,
  output logic [WIDTH-1:0] we
);
  for (genvar i = 0; i < WIDTH; i++) begin : g_we
    assign we[i] = din && (sel == SEL_W'(i));
  end
endmodule

// File: rtl/serial_deserializer.sv
// serial_deserializer: MSB-first serial-to-parallel receiver with a one-word output holding register.
// Optional even-parity checking is enabled by defining DESER_PARITY_EN.
module serial_deserializer
  import deser_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input logic clk,
  input logic reset_n,
  serial_deserializer_if.slave s
);
  localparam int FRAME = frame_len(WIDTH);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(FRAME - 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic [FRAME-1:0] asm_q, asm_d, asm_full, we;
  logic [WIDTH-1:0] data_q, data_d;
  logic err_q, err_d, vld_q, vld_d;
  logic last, take, load;
  assign last = cnt_q == LAST;
  assign s.in_ready = !(last && vld_q && !s.out_ready);
  assign take = s.in_valid && s.in_ready && !s.clear;
  assign load = take && last;
  demux1toN #(.WIDTH(FRAME), .SEL_W(CW)) u_demux (.din(take), .sel(cnt_q), .we(we));
  // counter value k writes assembly bit FRAME-1-k, so the first bit lands in the MSB
  always_comb begin
    asm_full = asm_q;
    for (int i = 0; i < FRAME; i++) asm_full[FRAME-1-i] = we[i] ? s.in_bit : asm_q[FRAME-1-i];
    cnt_d = s.clear ? '0 : take ? (last ? '0 : cnt_q + CW'(1)) : cnt_q;
    asm_d = s.clear ? '0 : asm_full;
    vld_d = load || (vld_q && !s.out_ready);
    data_d = load ? asm_full[FRAME-1 -: WIDTH] : data_q;
`ifdef DESER_PARITY_EN
    err_d = load ? ^asm_full : err_q;
`else
    err_d = 1'b0;
`endif
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
      asm_q <= '0;
      data_q <= '0;
      err_q <= 1'b0;
      vld_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      asm_q <= asm_d;
      data_q <= data_d;
      err_q <= err_d;
      vld_q <= vld_d;
    end
  end
  assign s.out_data = data_q;
  assign s.out_err = err_q;
  assign s.out_valid = vld_q;
endmodule
